alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle control sequencer that drives the 8-bit ALU from the other side of its OP/FUNC/flag interface.
- Fetches 9-bit instructions and decodes them into ALU_OP/ALU_FUNC.
- Owns the architectural FLAG and OVERFLOW status registers, fed back to the ALU as FLAG_IN/OVERFLOW_IN.
- Updates the PC, including taken branches signalled by the ALU.
- Sits between instruction memory, the ALU, the register file and data memory.

Parameters:
PC_W, 8, program counter / instruction address width
HALT_INSTR, 9'h1FF, instruction encoding that halts the sequencer

Ports:
CLK  in  1  clock, all state rising-edge
RESET  in  1  asynchronous, active-high; clears all state
START  in  1  pulse in IDLE/HALT begins execution at PC=0
INSTR_ADDR  out  PC_W  instruction memory address (= PC)
INSTR_DATA  in  9  instruction memory read data, valid same cycle as INSTR_ADDR
ALU_OP  out  3  opcode to ALU (instr[8:6]), encodings from definitions package
ALU_FUNC  out  3  func field to ALU (instr[2:0])
ALU_FLAG_IN  out  1  current FLAG register
ALU_OVERFLOW_IN  out  1  current OVERFLOW register
ALU_FLAG_OUT  in  1  ALU flag result
ALU_OVERFLOW_OUT  in  1  ALU carry/shift-out result
ALU_BRANCH_EN  in  1  ALU branch-taken indication
BR_LUT_IDX  out  3  branch target LUT index (instr[5:3])
BR_LUT_DATA  in  PC_W  absolute branch target from LUT
REG_WR_EN  out  1  register file write strobe
REG_WR_ADDR  out  3  destination register (instr[5:3])
MEM_RD_EN  out  1  data memory read strobe (opLW)
MEM_WR_EN  out  1  data memory write strobe (opSW)
BUSY  out  1  high from START accept until HALT
DONE  out  1  held high in HALT state
CYCLE_COUNT  out  16  executed-cycle counter (see Optional Feature)

Behaviour:
- Reset: state=IDLE; PC=0; IR=0; FLAG=0; OVERFLOW=0.
- Reset values of outputs: all strobes, BUSY and DONE are 0. ALU_OP/ALU_FUNC are 0.
- RESET asserted mid-instruction aborts it immediately. No pending write or strobe survives.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE: START=1 -> FETCH, with PC=0 and BUSY=1.
- HALT: DONE=1, BUSY=0. START=1 -> FETCH with PC=0; FLAG and OVERFLOW are cleared.
- FETCH (1 cycle): IR <= INSTR_DATA.
  - If INSTR_DATA==HALT_INSTR -> HALT, with PC unchanged.
  - Otherwise -> EXEC.
- EXEC (1 cycle): ALU_OP/ALU_FUNC/BR_LUT_IDX/REG_WR_ADDR are decoded from IR; the ALU result is combinational this cycle.
  - opLW: MEM_RD_EN=1 -> MEM.
  - opSW: MEM_WR_EN=1, no register write.
  - opADD, opSUB, opSEI, O-type shifts: REG_WR_EN=1. OVERFLOW <= ALU_OVERFLOW_OUT.
  - opCEQ, opCLT: FLAG <= ALU_FLAG_OUT. No register write. OVERFLOW unchanged.
  - FLAG is captured only on opCEQ/opCLT. ALU_FLAG_OUT is ignored for all other opcodes.
  - O-type branch funcs: no register write, FLAG/OVERFLOW unchanged.
    - ALU_BRANCH_EN=1 -> PC <= BR_LUT_DATA.
    - Otherwise PC <= PC+1.
  - All non-branch instructions: PC <= PC+1, wrapping modulo 2^PC_W (all-ones -> 0).
  - Next state FETCH (or MEM for opLW).
- MEM (1 cycle): REG_WR_EN=1 captures load data, PC <= PC+1 -> FETCH.
- Strobes are 1-cycle pulses, asserted only in EXEC/MEM, never in FETCH/IDLE/HALT.
- Latency: 2 cycles per instruction; 3 cycles for opLW.
- START is ignored while BUSY=1.
- Branch to own address (self-loop) is legal and repeats until RESET.

Optional Feature:
- Macro SEQ_CYCLE_COUNT_EN.
- Defined: CYCLE_COUNT increments every cycle BUSY=1, saturates at 16'hFFFF, clears on RESET and on accepted START, and holds in HALT.
- Undefined: CYCLE_COUNT is tied to 0 and no counter logic is synthesized.

Test Plan:
- RESET high mid-EXEC of opADD -> next cycle IDLE, REG_WR_EN=0, PC=0, FLAG=OVERFLOW=0.
- Program ADD, HALT_INSTR at 0,1; START -> REG_WR_EN pulse at cycle 2, DONE=1 after cycle 3 with PC=1; CYCLE_COUNT=3 with macro on.
- opCEQ with ALU_FLAG_OUT=1, then opSUB with ALU_FLAG_OUT=0, ALU_OVERFLOW_OUT=1 -> FLAG stays 1, OVERFLOW=1, ALU_FLAG_IN=1 on next instruction.
- Branch instr at PC=5, ALU_BRANCH_EN=1, BR_LUT_DATA=8'h20 -> next INSTR_ADDR=8'h20; with ALU_BRANCH_EN=0 -> 8'h06.
- opLW at PC=3 -> MEM_RD_EN pulse in EXEC, REG_WR_EN in MEM, next fetch at PC=4 after 3 cycles.
- Non-branch at PC=8'hFF -> PC wraps to 8'h00; START asserted while BUSY -> ignored, PC unaffected.

Source files
------------

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle control sequencer for the 8-bit ALU. It fetches 9-bit
// instructions, decodes them into the ALU OP/FUNC fields, and owns the
// architectural FLAG and OVERFLOW registers, which it feeds back to the ALU.
// It also updates the PC, including taken branches that the ALU reports, and
// strobes the register file and data memory.
//
// Optional feature: define SEQ_CYCLE_COUNT_EN to build the busy-cycle counter.
// When it is undefined, CYCLE_COUNT is tied to zero.
//
// Instruction format (9 bits):
//   [8:6] op    : ALU opcode
//   [5:3] rs    : destination register / branch LUT index
//   [2:0] func  : ALU function field
//
// Opcode encodings (shared with the ALU definitions):
//   0 add, 1 sub, 2 sei, 3 ceq, 4 clt, 5 lw, 6 sw, 7 O-type
//   O-type func[2]=0 : shift   (writes a register, updates OVERFLOW)
//   O-type func[2]=1 : branch  (ALU_BRANCH_EN selects the LUT target)
//
// Ports:
//   CLK, RESET           clock; asynchronous active-high reset
//   START                begins execution at PC=0 from IDLE or HALT
//   INSTR_ADDR/DATA      instruction memory address (=PC) and read data
//   ALU_OP/ALU_FUNC      decoded fields to the ALU
//   ALU_FLAG_IN          current FLAG register
//   ALU_OVERFLOW_IN      current OVERFLOW register
//   ALU_FLAG_OUT         ALU flag result
//   ALU_OVERFLOW_OUT     ALU carry/shift-out result
//   ALU_BRANCH_EN        ALU branch-taken indication
//   BR_LUT_IDX/DATA      branch target LUT index and absolute target
//   REG_WR_EN/ADDR       register file write strobe and destination
//   MEM_RD_EN/WR_EN      data memory strobes (lw / sw)
//   BUSY, DONE           running / halted status
//   CYCLE_COUNT          busy-cycle counter
//
// Strobe handshake: REG_WR_EN, MEM_RD_EN and MEM_WR_EN are single-cycle
// pulses with no back-pressure. A strobe is asserted for exactly one cycle,
// in EXEC or MEM, and the receiving block must accept it in that cycle.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int         PC_W       = 8,
    parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    output logic [PC_W-1:0] INSTR_ADDR,
    input  logic [8:0]      INSTR_DATA,
    output logic [2:0]      ALU_OP,
    output logic [2:0]      ALU_FUNC,
    output logic            ALU_FLAG_IN,
    output logic            ALU_OVERFLOW_IN,
    input  logic            ALU_FLAG_OUT,
    input  logic            ALU_OVERFLOW_OUT,
    input  logic            ALU_BRANCH_EN,
    output logic [2:0]      BR_LUT_IDX,
    input  logic [PC_W-1:0] BR_LUT_DATA,
    output logic            REG_WR_EN,
    output logic [2:0]      REG_WR_ADDR,
    output logic            MEM_RD_EN,
    output logic            MEM_WR_EN,
    output logic            BUSY,
    output logic            DONE,
    output logic [15:0]     CYCLE_COUNT
);

    // Opcode encodings.
    localparam logic [2:0] op_add   = 3'd0;
    localparam logic [2:0] op_sub   = 3'd1;
    localparam logic [2:0] op_sei   = 3'd2;
    localparam logic [2:0] op_ceq   = 3'd3;
    localparam logic [2:0] op_clt   = 3'd4;
    localparam logic [2:0] op_lw    = 3'd5;
    localparam logic [2:0] op_sw    = 3'd6;
    localparam logic [2:0] op_otype = 3'd7;

    localparam logic [PC_W-1:0] pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_fetch = 3'd1,
        st_exec  = 3'd2,
        st_mem   = 3'd3,
        st_halt  = 3'd4
    } state_t;

    // The state register is named plainly so checkers can bind to it.
    state_t          state;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic            flag_q;
    logic            ovf_q;
    logic            reg_wr_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic            busy_q;
    logic            done_q;

    // Fields of the instruction being fetched; used to pre-compute the
    // strobes that are registered for the following EXEC cycle.
    logic [2:0] f_op;
    logic [2:0] f_func;
    logic [2:0] x_op;
    logic [2:0] x_func;
    logic       start_accept;

    assign f_op   = INSTR_DATA[8:6];
    assign f_func = INSTR_DATA[2:0];
    assign x_op   = ir[8:6];
    assign x_func = ir[2:0];

    assign start_accept = START && ((state == st_idle) || (state == st_halt));

    // Instructions that write the register file from EXEC.
    function automatic logic writes_reg(input logic [2:0] op, input logic [2:0] func);
        return (op == op_add) || (op == op_sub) || (op == op_sei) ||
               ((op == op_otype) && !func[2]);
    endfunction

    // O-type branch functions.
    function automatic logic is_branch(input logic [2:0] op, input logic [2:0] func);
        return (op == op_otype) && func[2];
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= st_idle;
            pc       <= '0;
            ir       <= '0;
            flag_q   <= 1'b0;
            ovf_q    <= 1'b0;
            reg_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Strobes are pulses: they drop unless re-armed below.
            reg_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;

            case (state)
                st_idle: begin
                    if (START) begin
                        state  <= st_fetch;
                        pc     <= '0;
                        busy_q <= 1'b1;
                    end
                end

                st_fetch: begin
                    ir <= INSTR_DATA;
                    if (INSTR_DATA == HALT_INSTR) begin
                        // PC keeps pointing at the halt instruction.
                        state  <= st_halt;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state    <= st_exec;
                        reg_wr_q <= writes_reg(f_op, f_func);
                        mem_rd_q <= (f_op == op_lw);
                        mem_wr_q <= (f_op == op_sw);
                    end
                end

                st_exec: begin
                    // Status registers capture the combinational ALU result.
                    if ((x_op == op_ceq) || (x_op == op_clt)) begin
                        flag_q <= ALU_FLAG_OUT;
                    end
                    if (writes_reg(x_op, x_func)) begin
                        ovf_q <= ALU_OVERFLOW_OUT;
                    end

                    if (x_op == op_lw) begin
                        // Load data returns next cycle; PC advances in MEM.
                        state    <= st_mem;
                        reg_wr_q <= 1'b1;
                    end else begin
                        state <= st_fetch;
                        if (is_branch(x_op, x_func) && ALU_BRANCH_EN) begin
                            pc <= BR_LUT_DATA;
                        end else begin
                            pc <= pc + pc_one;
                        end
                    end
                end

                st_mem: begin
                    pc    <= pc + pc_one;
                    state <= st_fetch;
                end

                st_halt: begin
                    if (START) begin
                        state  <= st_fetch;
                        pc     <= '0;
                        flag_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end

                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

    assign INSTR_ADDR      = pc;
    assign ALU_OP          = x_op;
    assign ALU_FUNC        = x_func;
    assign BR_LUT_IDX      = ir[5:3];
    assign REG_WR_ADDR     = ir[5:3];
    assign ALU_FLAG_IN     = flag_q;
    assign ALU_OVERFLOW_IN = ovf_q;
    assign REG_WR_EN       = reg_wr_q;
    assign MEM_RD_EN       = mem_rd_q;
    assign MEM_WR_EN       = mem_wr_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;

`ifdef SEQ_CYCLE_COUNT_EN
    // Counts every cycle spent busy, saturating; holds while halted.
    logic [15:0] cycle_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cycle_cnt <= '0;
        end else if (start_accept) begin
            cycle_cnt <= '0;
        end else if (busy_q && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign CYCLE_COUNT = cycle_cnt;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign CYCLE_COUNT         = 16'd0;
`endif

endmodule
